ptch_fusion_integ: RTL and testbench

- Downstream consumer of the inertial interface. Takes the raw pitch-rate and Z-acceleration words on each vld strobe and produces a fused, drift-corrected signed pitch for the balance controller.
- First learns the gyro zero-rate offset by averaging a fixed number of samples. It then integrates the offset-corrected rate and applies complementary-filter correction toward the accelerometer-derived pitch.

---
 rtl/ptch_fusion_integ_pkg.sv | 25 ++
 rtl/ptch_fusion_integ_if.sv | 20 ++
 rtl/ptch_fusion_integ_offset_cal.sv | 55 +++++
 rtl/ptch_fusion_integ.sv | 113 +++++++++++
 tb/tb_ptch_fusion_integ.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ptch_fusion_integ_pkg.sv
// Shared types and constants for the pitch fusion integrator.
// Holds the state encoding, the accelerometer scaling and the integrator width.
package ptch_pkg;

   typedef enum logic {
      CAL = 1'b0,
      RUN = 1'b1
   } state_t;

   localparam int ACC_SCALE = 327;
   localparam int ACC_SHIFT = 13;
   localparam int INT_W     = 27;
   localparam int PTCH_LSB  = 11;

   // Clamp a two-bit-wider sum back into the integrator range.
   function automatic logic signed [INT_W-1:0] sat_int(input logic signed [INT_W+1:0] v);
      if (v > $signed({3'b000, {(INT_W-1){1'b1}}}))
         return {1'b0, {(INT_W-1){1'b1}}};
      else if (v < $signed({3'b111, {(INT_W-1){1'b0}}}))
         return {1'b1, {(INT_W-1){1'b0}}};
      else
         return v[INT_W-1:0];
   endfunction

endpackage

// File: rtl/ptch_fusion_integ_if.sv
// Sample/result bus between the inertial front end and the pitch fusion block.
interface ptch_fusion_integ_if;
   logic               vld;
   logic signed [15:0] ptch_rt;
   logic signed [15:0] AZ;
   logic               cal_req;
   logic signed [15:0] ptch;
   logic               ptch_vld;
   logic               cal_done;

   modport master (
      output vld, ptch_rt, AZ, cal_req,
      input  ptch, ptch_vld, cal_done
   );

   modport slave (
      input  vld, ptch_rt, AZ, cal_req,
      output ptch, ptch_vld, cal_done
   );
endinterface

// File: rtl/ptch_fusion_integ_offset_cal.sv
// Gyro zero-rate offset learner: averages 2^CAL_LOG2 rate samples.
// The offset register survives a restart until the next average completes.
module ptch_offset_cal
   import ptch_pkg::*;
#(
   parameter int CAL_LOG2 = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   input  logic               i_vld,
   input  logic               i_clr,
   input  logic signed [15:0] i_rt,
   output logic signed [15:0] o_offset,
   output logic               o_cal_complete
);

   localparam int ACC_W = 16 + CAL_LOG2;

   logic signed [ACC_W-1:0]  r_cal_acc;
   logic [CAL_LOG2-1:0]      r_cal_cnt;
   logic signed [15:0]       r_offset;
   logic signed [ACC_W-1:0]  w_acc_next;
   logic                     w_take;
   logic                     w_last;

   assign w_take     = i_en & i_vld & ~i_clr;
   assign w_last     = w_take & (r_cal_cnt == {CAL_LOG2{1'b1}});
   assign w_acc_next = r_cal_acc + ACC_W'(i_rt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cal_acc <= '0;
         r_cal_cnt <= '0;
         r_offset  <= '0;
      end else if (i_clr) begin
         r_cal_acc <= '0;
         r_cal_cnt <= '0;
      end else if (w_take) begin
         if (w_last) begin
            // arithmetic shift gives floor rounding for negative sums
            r_offset  <= 16'(w_acc_next >>> CAL_LOG2);
            r_cal_acc <= '0;
            r_cal_cnt <= '0;
         end else begin
            r_cal_acc <= w_acc_next;
            r_cal_cnt <= r_cal_cnt + 1'b1;
         end
      end
   end

   assign o_offset       = r_offset;
   assign o_cal_complete = w_last;

endmodule

// File: rtl/ptch_fusion_integ.sv
// Fused pitch estimator: offset-corrected gyro integration with a fixed-step
// complementary correction toward the accelerometer pitch.
//
//   state | meaning
//   CAL   | averaging gyro samples to learn the zero-rate offset, ptch held at 0
//   RUN   | offset valid, each sample goes through the 2-stage integrate pipeline
module ptch_fusion_integ
   import ptch_pkg::*;
#(
   parameter int                 CAL_LOG2    = 4,
   parameter logic signed [15:0] AZ_OFFSET   = 16'sh00A0,
   parameter int                 FUSION_GAIN = 1024
) (
   input  logic          clk,
   input  logic          rst,
   ptch_fusion_integ_if.slave bus
);

   localparam int SUM_W = INT_W + 2;

   state_t                   r_state;
   logic signed [16:0]       r_comp;
   logic signed [15:0]       r_ptch_acc;
   logic                     r_s1_vld;
   logic signed [INT_W-1:0]  r_ptch_int;
   logic signed [15:0]       r_ptch;
   logic                     r_ptch_vld;
   logic                     r_cal_done;

   logic signed [15:0]       w_offset;
   logic                     w_cal_complete;
   logic                     w_in_cal;
   logic signed [16:0]       w_comp;
   logic signed [16:0]       w_azc;
   logic signed [INT_W-1:0]  w_prod;
   logic signed [SUM_W-1:0]  w_fus;
   logic signed [SUM_W-1:0]  w_sum;
   logic signed [INT_W-1:0]  w_int_next;

   assign w_in_cal = (r_state == CAL);

   ptch_offset_cal #(
      .CAL_LOG2 (CAL_LOG2)
   ) u_offset_cal (
      .clk            (clk),
      .rst            (rst),
      .i_en           (w_in_cal),
      .i_vld          (bus.vld),
      .i_clr          (bus.cal_req),
      .i_rt           (bus.ptch_rt),
      .o_offset       (w_offset),
      .o_cal_complete (w_cal_complete)
   );

   assign w_comp = 17'(bus.ptch_rt) - 17'(w_offset);
   assign w_azc  = 17'(bus.AZ) - 17'(AZ_OFFSET);
   assign w_prod = INT_W'(w_azc) * INT_W'(ACC_SCALE);

   // correction direction is decided against the pitch already on the output
   assign w_fus      = (r_ptch_acc > r_ptch) ? SUM_W'(FUSION_GAIN) : -SUM_W'(FUSION_GAIN);
   assign w_sum      = SUM_W'(r_ptch_int) - SUM_W'(r_comp) + w_fus;
   assign w_int_next = sat_int(w_sum);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= CAL;
         r_comp     <= '0;
         r_ptch_acc <= '0;
         r_s1_vld   <= 1'b0;
         r_ptch_int <= '0;
         r_ptch     <= '0;
         r_ptch_vld <= 1'b0;
         r_cal_done <= 1'b0;
      end else begin
         r_s1_vld   <= 1'b0;
         r_ptch_vld <= 1'b0;
         if (bus.cal_req) begin
            r_state    <= CAL;
            r_ptch_int <= '0;
            r_ptch     <= '0;
            r_cal_done <= 1'b0;
         end else begin
            case (r_state)
               CAL: begin
                  if (w_cal_complete) begin
                     r_state    <= RUN;
                     r_ptch_int <= '0;
                     r_cal_done <= 1'b1;
                  end
               end
               RUN: begin
                  if (bus.vld) begin
                     r_s1_vld   <= 1'b1;
                     r_comp     <= w_comp;
                     r_ptch_acc <= 16'(w_prod >>> ACC_SHIFT);
                  end
                  if (r_s1_vld) begin
                     r_ptch_int <= w_int_next;
                     r_ptch     <= w_int_next[PTCH_LSB +: 16];
                     r_ptch_vld <= 1'b1;
                  end
               end
               default: r_state <= CAL;
            endcase
         end
      end
   end

   assign bus.ptch     = r_ptch;
   assign bus.ptch_vld = r_ptch_vld;
   assign bus.cal_done = r_cal_done;

endmodule

// File: tb/tb_ptch_fusion_integ.sv
// Bench for ptch_fusion_integ: directed scenarios plus random traffic, all
// compared every cycle against an arithmetic model of the fusion rules.
module tb_ptch_fusion_integ;
   localparam int     CAL_N = 16;
   localparam int     GAIN  = 1024;
   localparam int     AZOFF = 160;
   localparam longint IMAX  = (64'sd1 <<< 26) - 1;
   localparam longint IMIN  = -(64'sd1 <<< 26);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_pv = 0;
   bit   cmp_en = 1'b0;

   ptch_fusion_integ_if ifc ();

   ptch_fusion_integ #(
      .CAL_LOG2    (4),
      .AZ_OFFSET   (16'sh00A0),
      .FUSION_GAIN (1024)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // model: sample list for calibration, queue of (comp, accel pitch) in flight
   bit     m_cal;
   int     m_samp[$];
   int     m_offset;
   longint m_int;
   int     m_ptch;
   bit     m_vld;
   int     m_pc[$];
   int     m_pa[$];

   always @(posedge clk or posedge rst) begin
      int c, a, s;
      if (rst) begin
         m_cal = 0; m_samp.delete(); m_offset = 0; m_int = 0; m_ptch = 0; m_vld = 0;
         m_pc.delete(); m_pa.delete();
      end else begin
         m_vld = 0;
         if (ifc.cal_req) begin
            m_cal = 0; m_samp.delete(); m_int = 0; m_ptch = 0;
            m_pc.delete(); m_pa.delete();
         end else begin
            while (m_pc.size() > 0) begin
               c = m_pc.pop_front();
               a = m_pa.pop_front();
               m_int = m_int - c + ((a > m_ptch) ? GAIN : -GAIN);
               if (m_int > IMAX) m_int = IMAX;
               if (m_int < IMIN) m_int = IMIN;
               m_ptch = int'(m_int >>> 11);
               m_vld = 1;
            end
            if (ifc.vld) begin
               if (!m_cal) begin
                  m_samp.push_back(int'(ifc.ptch_rt));
                  if (m_samp.size() == CAL_N) begin
                     s = 0;
                     foreach (m_samp[i]) s += m_samp[i];
                     m_offset = s >>> 4;
                     m_cal = 1; m_int = 0;
                     m_samp.delete();
                  end
               end else begin
                  m_pc.push_back(int'(ifc.ptch_rt) - m_offset);
                  m_pa.push_back(((int'(ifc.AZ) - AZOFF) * 327) >>> 13);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ptch", ifc.ptch, m_ptch);
         check("ptch_vld", ifc.ptch_vld, m_vld);
         check("cal_done", ifc.cal_done, m_cal);
         if (ifc.ptch_vld) n_pv++;
      end
   end

   task automatic cyc(input bit v, input logic [15:0] rt, input logic [15:0] az, input bit cr);
      ifc.vld = v; ifc.ptch_rt = rt; ifc.AZ = az; ifc.cal_req = cr;
      @(negedge clk);
   endtask

   task automatic calib(input logic [15:0] rt);
      repeat (CAL_N) cyc(1'b1, rt, 16'h00A0, 1'b0);
   endtask

   initial begin
      int pv0;
      ifc.vld = 0; ifc.ptch_rt = '0; ifc.AZ = '0; ifc.cal_req = 0;
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      check("rst_ptch", ifc.ptch, 0);
      check("rst_ptch_vld", ifc.ptch_vld, 0);
      check("rst_cal_done", ifc.cal_done, 0);
      rst = 1'b0;

      // first calibration: 15 samples are not enough
      repeat (CAL_N - 1) cyc(1'b1, 16'h0040, 16'h00A0, 1'b0);
      check("cal15_done", ifc.cal_done, 0);
      check("cal15_no_pv", n_pv, 0);
      cyc(1'b1, 16'h0040, 16'h00A0, 1'b0);
      check("cal16_done", ifc.cal_done, 1);
      check("model_offset_40", m_offset, 64);

      // zero stimulus: first step pulls to -1, second pushes back to 0
      cyc(1'b1, 16'h0040, 16'h00A0, 1'b0);
      cyc(1'b1, 16'h0040, 16'h00A0, 1'b0);
      check("zero_pv_latency", ifc.ptch_vld, 1);
      check("zero_ptch1", ifc.ptch, -1);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0);
      check("zero_ptch2", ifc.ptch, 0);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0);
      check("zero_idle_pv", ifc.ptch_vld, 0);

      // floor-rounded offset from a negative average
      cyc(1'b0, 16'h0000, 16'h0000, 1'b1);
      repeat (CAL_N / 2) begin
         cyc(1'b1, 16'hFFFF, 16'h00A0, 1'b0);
         cyc(1'b1, 16'hFFFE, 16'h00A0, 1'b0);
      end
      check("floor_cal_done", ifc.cal_done, 1);
      check("model_offset_floor", m_offset, -2);
      cyc(1'b1, 16'hFBFF, 16'h00A0, 1'b0);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0);
      check("floor_ptch", ifc.ptch, -1);

      // fusion: +768 per step over 8 steps
      cyc(1'b0, 16'h0000, 16'h0000, 1'b1);
      calib(16'h0040);
      repeat (8) cyc(1'b1, 16'h0140, 16'h10A0, 1'b0);
      repeat (2) cyc(1'b0, 16'h0000, 16'h0000, 1'b0);
      check("fusion_ptch", ifc.ptch, 3);
      check("model_fusion_int", m_int, 6144);

      // random traffic with occasional recalibration
      for (int i = 0; i < 800; i++)
         cyc($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
             $urandom_range(0, 149) == 0);

      // saturation at the positive integrator limit
      cyc(1'b0, 16'h0000, 16'h0000, 1'b1);
      calib(16'h0040);
      pv0 = n_pv;
      repeat (2300) cyc(1'b1, 16'h8000, 16'h40A0, 1'b0);
      repeat (2) cyc(1'b0, 16'h0000, 16'h0000, 1'b0);
      check("sat_ptch", ifc.ptch, 32767);
      check("sat_pv_count", n_pv - pv0, 2300);
      check("model_sat_int", m_int, IMAX);

      // recalibration with one sample in s1 and one colliding with cal_req
      cyc(1'b1, 16'h0040, 16'h00A0, 1'b0);
      pv0 = n_pv;
      cyc(1'b1, 16'h0040, 16'h10A0, 1'b1);
      check("recal_done", ifc.cal_done, 0);
      check("recal_ptch", ifc.ptch, 0);
      repeat (3) cyc(1'b0, 16'h0000, 16'h0000, 1'b0);
      check("recal_flush_pv", n_pv - pv0, 0);
      repeat (CAL_N - 1) cyc(1'b1, 16'h0040, 16'h00A0, 1'b0);
      check("recal15_done", ifc.cal_done, 0);
      cyc(1'b1, 16'h0040, 16'h00A0, 1'b0);
      check("recal16_done", ifc.cal_done, 1);

      // asynchronous reset with data in the pipeline
      cyc(1'b1, 16'h0140, 16'h10A0, 1'b0);
      cyc(1'b1, 16'h0140, 16'h10A0, 1'b0);
      ifc.vld = 0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_ptch", ifc.ptch, 0);
      check("arst_pv", ifc.ptch_vld, 0);
      check("arst_done", ifc.cal_done, 0);
      @(negedge clk);
      rst = 1'b0;
      calib(16'h0040);
      repeat (4) cyc(1'b1, 16'h0140, 16'h10A0, 1'b0);
      repeat (3) cyc(1'b0, 16'h0000, 16'h0000, 1'b0);
      check("post_rst_ptch", ifc.ptch, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
